ftoi_pipe: RTL and testbench
============================

// Module: ftoi_pipe
// PURPOSE
//  Pipelined IEEE-754 binary32 -> integer converter, successor to the single-cycle ftoi.
//  Adds parametrised result width, signed/unsigned modes and five rounding modes.
//  Clamps out-of-range and NaN inputs to saturated values and raises NV/NX flags.
//  Uses a valid/ready handshake with full backpressure. Sits in the FPU convert path.
// PARAMETERS
//  OUT_W   32  integer result width; legal range 16..64
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  in_valid     in   1      input beat valid
//  in_ready     out  1      converter can accept a beat this cycle
//  in_data      in   32     binary32 operand {s, e[7:0], m[22:0]}
//  in_rm        in   3      rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//  in_unsigned  in   1      1 = unsigned result, 0 = two's-complement result
//  out_valid    out  1      result beat valid
//  out_ready    in   1      consumer accepts the result
//  out_data     out  OUT_W  integer result
//  out_nv       out  1      invalid flag
//  out_nx       out  1      inexact flag
// BEHAVIOUR
//  Reset (async, active-high): s1_valid=0, out_valid=0, out_data=0, out_nv=0, out_nx=0.
//   A reset mid-operation discards all in-flight beats; no beat emerges after reset.
//  Pipeline has two register stages; latency is 2 cycles when out_ready=1.
//   S1: unpack the operand, classify (zero/denorm/normal/inf/NaN) and align the
//       significand to integer position.
//       Capture integer magnitude, guard bit and sticky bit (sticky = OR of the lower bits).
//   S2 (output regs): round increment, negate, range check, saturate, flags.
//  Handshake:
//   adv2 = !out_valid | out_ready;  adv1 = !s1_valid | adv2;  in_ready = adv1.
//   in_ready is combinational from out_ready.
//   Input is accepted when in_valid & in_ready; in_rm and in_unsigned travel with the beat.
//   While out_valid & !out_ready, out_data, out_nv and out_nx hold stable.
//   No beat is lost, duplicated or reordered. Full throughput is 1 beat/cycle.
//  Rounding increment:
//   RNE: g & (sticky | lsb).  RTZ: 0.  RMM: g.
//   RDN: s & (g|sticky).  RUP: !s & (g|sticky).
//   rm 101..111 are treated as RTZ and raise no extra flag.
//  Range:
//   signed results lie in [-2^(OUT_W-1), 2^(OUT_W-1)-1]; unsigned in [0, 2^OUT_W-1].
//   The range check is applied to the rounded value.
//   Exponents too large for the shifter saturate directly.
//  Special cases:
//   zero or -0: result 0, no flags.
//   denorm: treated as nonzero magnitude < 1, so it rounds (e.g. RUP of +denorm -> 1, NX=1).
//   NaN: signed -> 2^(OUT_W-1)-1, unsigned -> all ones; NV=1.
//   +inf or positive overflow: signed max / unsigned all ones; NV=1.
//   -inf or negative overflow: signed -> 2^(OUT_W-1), unsigned -> 0; NV=1.
//   unsigned mode, negative input rounding to 0: result 0, NX per lost bits, NV=0.
//   unsigned mode, negative input rounding to nonzero: result 0, NV=1.
//  Flags: NX = (g|sticky) for in-range results only. NV and NX are never both set.
// TESTING
//  Default OUT_W=32 unless noted.
//  0x40490FDB (pi): RNE -> 3, NX=1; RUP -> 4, NX=1; RTZ -> 3, NX=1.
//  0xC0200000 (-2.5): RNE -> 0xFFFFFFFE; RMM -> 0xFFFFFFFD; RDN -> 0xFFFFFFFD; RTZ -> 0xFFFFFFFE.
//  0x4F000000 signed -> 0x7FFFFFFF NV=1; 0xCF000000 signed -> 0x80000000, no flags.
//   0x4F800000 unsigned -> 0xFFFFFFFF NV=1.
//  0x7FC00000 signed -> 0x7FFFFFFF NV=1; 0xBF800000 unsigned -> 0 NV=1.
//   0xBE800000 unsigned RTZ -> 0 NX=1 NV=0.
//  Backpressure: 8 back-to-back beats with out_ready pattern 1,0,0,1,1,0,1,1...
//   -> all 8 results in order; outputs stable while stalled.
//  Reset with 2 beats in flight -> out_valid=0 immediately; nothing emerges afterwards.
//   in_ready=1 after release. OUT_W=64: 0x5F000000 signed -> 0x7FFF_FFFF_FFFF_FFFF NV=1.

Source files
------------

// File: rtl/ftoi_pipe.sv
// Two-stage pipelined binary32 -> integer converter: five rounding modes,
// signed/unsigned saturation, NV/NX flags, valid/ready handshake with backpressure.
module ftoi_pipe #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [2:0]       in_rm,
    input  logic             in_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_nv,
    output logic             out_nx
);
    // The significand is shifted into a fixed-point window with 48 fraction bits,
    // so the integer part, guard bit and sticky bits fall at fixed positions.
    localparam int                WW   = OUT_W + 48;
    localparam logic signed [9:0] EMAX = 10'(OUT_W);
    localparam logic [OUT_W:0]    HALF = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]  SMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  SMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]  UMAX = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0]  ZERO = {OUT_W{1'b0}};

    logic                    adv1_s, adv2_s;
    logic                    sgn_s;
    logic [7:0]              exp_s;
    logic [22:0]             man_s;
    logic signed [9:0]       eun_s;
    logic [9:0]              sh_s;
    logic [WW-1:0]           wide_s;
    logic [OUT_W-1:0]        mag_s;
    logic                    g_s, st_s, nan_s, big_s;

    logic                    s1_valid_r, s1_sign_r, s1_g_r, s1_st_r;
    logic                    s1_nan_r, s1_big_r, s1_uns_r;
    logic [2:0]              s1_rm_r;
    logic [OUT_W-1:0]        s1_mag_r;

    logic                    inc_s, lost_s, nv_s, nx_s;
    logic [OUT_W:0]          rnd_s;
    logic [OUT_W-1:0]        res_s;

    assign adv2_s   = !out_valid | out_ready;
    assign adv1_s   = !s1_valid_r | adv2_s;
    assign in_ready = adv1_s;

    assign sgn_s = in_data[31];
    assign exp_s = in_data[30:23];
    assign man_s = in_data[22:0];
    assign eun_s = $signed({2'b00, exp_s}) - 10'sd127;
    assign sh_s  = eun_s + 10'sd25;

    // Stage 1 classification and alignment of the operand
    always_comb begin
        wide_s = {{(WW-24){1'b0}}, 1'b1, man_s} << sh_s;
        mag_s  = ZERO;
        g_s    = 1'b0;
        st_s   = 1'b0;
        nan_s  = 1'b0;
        big_s  = 1'b0;
        if (exp_s == 8'hFF) begin
            nan_s = (man_s != 23'd0);
            big_s = (man_s == 23'd0);
        end else if (exp_s == 8'h00) begin
            // denormals are a nonzero magnitude below one half
            st_s = (man_s != 23'd0);
        end else if (eun_s >= EMAX) begin
            big_s = 1'b1;
        end else if (eun_s >= -10'sd1) begin
            mag_s = wide_s[WW-1:48];
            g_s   = wide_s[47];
            st_s  = |wide_s[46:0];
        end else begin
            st_s = 1'b1;
        end
    end

    // Stage 1 registers, loaded whenever the stage can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_mag_r   <= ZERO;
            s1_g_r     <= 1'b0;
            s1_st_r    <= 1'b0;
            s1_nan_r   <= 1'b0;
            s1_big_r   <= 1'b0;
            s1_rm_r    <= 3'd0;
            s1_uns_r   <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= sgn_s;
                s1_mag_r  <= mag_s;
                s1_g_r    <= g_s;
                s1_st_r   <= st_s;
                s1_nan_r  <= nan_s;
                s1_big_r  <= big_s;
                s1_rm_r   <= in_rm;
                s1_uns_r  <= in_unsigned;
            end
        end
    end

    // Rounding increment; unused mode encodings truncate
    always_comb begin
        case (s1_rm_r)
            3'b000:  inc_s = s1_g_r & (s1_st_r | s1_mag_r[0]);
            3'b010:  inc_s = s1_sign_r & (s1_g_r | s1_st_r);
            3'b011:  inc_s = !s1_sign_r & (s1_g_r | s1_st_r);
            3'b100:  inc_s = s1_g_r;
            default: inc_s = 1'b0;
        endcase
    end

    assign rnd_s  = {1'b0, s1_mag_r} + {{OUT_W{1'b0}}, inc_s};
    assign lost_s = s1_g_r | s1_st_r;

    // Range check on the rounded magnitude, saturation and flag generation
    always_comb begin
        res_s = ZERO;
        nv_s  = 1'b0;
        nx_s  = 1'b0;
        if (s1_nan_r) begin
            res_s = s1_uns_r ? UMAX : SMAX;
            nv_s  = 1'b1;
        end else if (s1_big_r) begin
            res_s = s1_sign_r ? (s1_uns_r ? ZERO : SMIN) : (s1_uns_r ? UMAX : SMAX);
            nv_s  = 1'b1;
        end else if (s1_uns_r) begin
            if (s1_sign_r) begin
                // negative values survive only when they round to zero
                res_s = ZERO;
                nv_s  = (rnd_s != {(OUT_W+1){1'b0}});
                nx_s  = (rnd_s == {(OUT_W+1){1'b0}}) & lost_s;
            end else if (rnd_s[OUT_W]) begin
                res_s = UMAX;
                nv_s  = 1'b1;
            end else begin
                res_s = rnd_s[OUT_W-1:0];
                nx_s  = lost_s;
            end
        end else begin
            if (s1_sign_r) begin
                if (rnd_s > HALF) begin
                    res_s = SMIN;
                    nv_s  = 1'b1;
                end else begin
                    res_s = ZERO - rnd_s[OUT_W-1:0];
                    nx_s  = lost_s;
                end
            end else if (rnd_s >= HALF) begin
                res_s = SMAX;
                nv_s  = 1'b1;
            end else begin
                res_s = rnd_s[OUT_W-1:0];
                nx_s  = lost_s;
            end
        end
    end

    // Output registers hold their value while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= ZERO;
            out_nv    <= 1'b0;
            out_nx    <= 1'b0;
        end else if (adv2_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data <= res_s;
                out_nv   <= nv_s;
                out_nx   <= nx_s;
            end
        end
    end
endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: directed vectors, backpressure, reset in flight,
// and randomized beats checked against a real-arithmetic reference model.
module tb_ftoi_pipe;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_unsigned;
    logic [31:0] in_data;
    logic [2:0]  in_rm;
    logic        out_valid, out_ready, out_nv, out_nx;
    logic [31:0] out_data;

    logic        v64, rdy64, u64, ov64, ordy64, nv64, nx64;
    logic [31:0] d64;
    logic [2:0]  rm64;
    logic [63:0] od64;

    ftoi_pipe #(.OUT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rm(in_rm), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nv(out_nv), .out_nx(out_nx)
    );

    ftoi_pipe #(.OUT_W(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64), .in_ready(rdy64), .in_data(d64),
        .in_rm(rm64), .in_unsigned(u64),
        .out_valid(ov64), .out_ready(ordy64), .out_data(od64),
        .out_nv(nv64), .out_nx(nx64)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        nv;
        logic        nx;
    } res_t;

    int         checks = 0;
    int         errors = 0;
    res_t       expq[$];
    int         bp_mode = 1;
    int         cyc = 0;
    logic [7:0] bp_pat = 8'hD9;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [63:0] d, input logic nv, input logic nx);
        res_t o;
        o.d  = d;
        o.nv = nv;
        o.nx = nx;
        return o;
    endfunction

    function automatic real pow2(input int k);
        real p = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) p = p * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) p = p / 2.0;
        end
        return p;
    endfunction

    function automatic logic [63:0] to_u64(input real r);
        real    hi, lo;
        longint hl, ll;
        logic [63:0] x;
        hi = $floor(r / 4294967296.0);
        lo = r - hi * 4294967296.0;
        hl = longint'(hi);
        ll = longint'(lo);
        x  = {hl[31:0], ll[31:0]};
        return x;
    endfunction

    // Reference: decode the float to an exact real, round it, then range-check.
    function automatic res_t model(input logic [31:0] f, input logic [2:0] rm,
                                   input logic uns, input int w);
        res_t        o;
        real         v, t, fr, r, sv;
        logic        s, up;
        int          e, m;
        logic [63:0] mask, mag;
        s    = f[31];
        e    = int'(f[30:23]);
        m    = int'(f[22:0]);
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        o    = '0;
        if (e == 255 && m != 0) begin
            o.nv = 1'b1;
            o.d  = uns ? mask : (mask >> 1);
            return o;
        end
        if (e == 255) v = pow2(200);
        else if (e == 0) v = real'(m) * pow2(-149);
        else v = real'(m + 8388608) * pow2(e - 150);
        t  = $floor(v);
        fr = v - t;
        case (rm)
            3'd0:    up = (fr > 0.5) || (fr == 0.5 && (t - 2.0 * $floor(t / 2.0)) == 1.0);
            3'd2:    up = s && (fr > 0.0);
            3'd3:    up = !s && (fr > 0.0);
            3'd4:    up = (fr >= 0.5);
            default: up = 1'b0;
        endcase
        r  = up ? t + 1.0 : t;
        sv = s ? -r : r;
        if (uns) begin
            if (sv >= pow2(w)) begin
                o.nv = 1'b1;
                o.d  = mask;
            end else if (sv < 0.0) begin
                o.nv = 1'b1;
            end else begin
                o.d  = to_u64(r);
                o.nx = (fr != 0.0);
            end
        end else begin
            if (sv >= pow2(w - 1)) begin
                o.nv = 1'b1;
                o.d  = mask >> 1;
            end else if (sv < -pow2(w - 1)) begin
                o.nv = 1'b1;
                o.d  = 64'd1 << (w - 1);
            end else begin
                mag  = to_u64(r);
                o.d  = (s ? (~mag + 64'd1) : mag) & mask;
                o.nx = (fr != 0.0);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] rnd_float(input int w);
        logic [7:0] e;
        int         sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else e = 8'($urandom_range(118, 128 + w));
        if (sel == 2) return {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
        if (sel == 3) return {1'($urandom_range(0, 1)), 31'd0};
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (bp_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = bp_pat[cyc % 8];
            default: out_ready = (($urandom % 3) != 0);
        endcase
    endtask

    task automatic send(input logic [31:0] f, input logic [2:0] rm, input logic uns, input res_t e);
        bit ok = 1'b0;
        in_valid    = 1'b1;
        in_data     = f;
        in_rm       = rm;
        in_unsigned = uns;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        check("accept_wait", {63'd0, ok}, 64'd1);
        if (ok) expq.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] f, input logic [2:0] rm, input logic uns);
        send(f, rm, uns, model(f, rm, uns, 32));
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    task automatic send64(input logic [31:0] f, input logic [2:0] rm, input logic uns, input res_t e);
        v64  = 1'b1;
        d64  = f;
        rm64 = rm;
        u64  = uns;
        tick();
        v64 = 1'b0;
        tick();
        check("w64_valid", {63'd0, ov64}, 64'd1);
        check("w64_data", od64, e.d);
        check("w64_nv", {63'd0, nv64}, {63'd0, e.nv});
        check("w64_nx", {63'd0, nx64}, {63'd0, e.nx});
    endtask

    // Output monitor: every valid cycle must present the oldest outstanding result
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                check("out_data", {32'd0, out_data}, expq[0].d);
                check("out_nv", {63'd0, out_nv}, {63'd0, expq[0].nv});
                check("out_nx", {63'd0, out_nx}, {63'd0, expq[0].nx});
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_rm = 3'd0; in_unsigned = 1'b0;
        out_ready = 1'b1; v64 = 1'b0; d64 = 32'd0; rm64 = 3'd0; u64 = 1'b0; ordy64 = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_nv", {63'd0, out_nv}, 64'd0);
        check("rst_out_nx", {63'd0, out_nx}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        tick();
        rst = 1'b0;

        bp_mode = 1;
        send(32'h40490FDB, 3'd0, 1'b0, mk(64'd3, 1'b0, 1'b1));
        send(32'h40490FDB, 3'd3, 1'b0, mk(64'd4, 1'b0, 1'b1));
        send(32'h40490FDB, 3'd1, 1'b0, mk(64'd3, 1'b0, 1'b1));
        send(32'hC0200000, 3'd0, 1'b0, mk(64'hFFFF_FFFE, 1'b0, 1'b1));
        send(32'hC0200000, 3'd4, 1'b0, mk(64'hFFFF_FFFD, 1'b0, 1'b1));
        send(32'hC0200000, 3'd2, 1'b0, mk(64'hFFFF_FFFD, 1'b0, 1'b1));
        send(32'hC0200000, 3'd1, 1'b0, mk(64'hFFFF_FFFE, 1'b0, 1'b1));
        send(32'h4F000000, 3'd0, 1'b0, mk(64'h7FFF_FFFF, 1'b1, 1'b0));
        send(32'hCF000000, 3'd0, 1'b0, mk(64'h8000_0000, 1'b0, 1'b0));
        send(32'h4F800000, 3'd0, 1'b1, mk(64'hFFFF_FFFF, 1'b1, 1'b0));
        send(32'h7FC00000, 3'd0, 1'b0, mk(64'h7FFF_FFFF, 1'b1, 1'b0));
        send(32'hBF800000, 3'd0, 1'b1, mk(64'd0, 1'b1, 1'b0));
        send(32'hBE800000, 3'd1, 1'b1, mk(64'd0, 1'b0, 1'b1));
        send(32'h00000001, 3'd3, 1'b0, mk(64'd1, 1'b0, 1'b1));
        send(32'h80000000, 3'd0, 1'b0, mk(64'd0, 1'b0, 1'b0));
        send(32'hFF800000, 3'd0, 1'b0, mk(64'h8000_0000, 1'b1, 1'b0));
        send(32'hFF800000, 3'd0, 1'b1, mk(64'd0, 1'b1, 1'b0));
        send(32'h3F000000, 3'd0, 1'b0, mk(64'd0, 1'b0, 1'b1));
        send(32'h3F000000, 3'd4, 1'b0, mk(64'd1, 1'b0, 1'b1));
        send(32'h3FC00000, 3'd7, 1'b0, mk(64'd1, 1'b0, 1'b1));
        drain();

        bp_mode = 2;
        cyc = 0;
        out_ready = bp_pat[0];
        for (int i = 0; i < 8; i++) send_m(rnd_float(32), 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        drain();

        bp_mode = 3;
        for (int i = 0; i < 300; i++) send_m(rnd_float(32), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        drain();

        bp_mode = 0;
        out_ready = 1'b0;
        send_m(32'h40490FDB, 3'd0, 1'b0);
        send_m(32'hC0200000, 3'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_flight_out_valid", {63'd0, out_valid}, 64'd0);
        expq.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        bp_mode = 1;
        out_ready = 1'b1;
        repeat (6) tick();
        check("post_rst_no_beat", {63'd0, out_valid}, 64'd0);

        send64(32'h5F000000, 3'd0, 1'b0, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0));
        send64(32'hDF000000, 3'd0, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b0));
        send64(32'h5F800000, 3'd0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0));
        for (int i = 0; i < 40; i++) begin
            logic [31:0] f;
            logic [2:0]  rm;
            logic        u;
            f  = rnd_float(64);
            rm = 3'($urandom_range(0, 7));
            u  = 1'($urandom_range(0, 1));
            send64(f, rm, u, model(f, rm, u, 64));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
